// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and defaults for the receive control unit
//
// Purpose: FSM state encoding and default watchdog sizing shared by
// rx_rcu and rx_watchdog. No ports.

package rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_CLR = 3'd1,
    ST_RECEIVE   = 3'd2,
    ST_CHECK     = 3'd3,
    ST_LOAD      = 3'd4,
    ST_ERR       = 3'd5
  } rx_state_t;

  // Clocks allowed in RECEIVE without a sample_tick before the frame aborts.
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  // Watchdog counter width; 2**DEFAULT_TO_BITS must cover DEFAULT_TIMEOUT_CYCLES.
  localparam int DEFAULT_TO_BITS        = 7;

endpackage

// File: rtl/rx_rcu_if.sv
// rtl/rx_rcu_if.sv - control/status bundle between rx_rcu and the receiver datapath
//
// Purpose: groups the receive control unit's datapath-facing signals.
// Signals:
//   start_bit_detected  datapath -> rcu  one-cycle start pulse from edge detector
//   sample_tick         datapath -> rcu  bit-period counter rollover (mid-bit)
//   bits_done           datapath -> rcu  bit-count counter rollover
//   stop_bit            datapath -> rcu  sampled stop bit
//   timer_clear         rcu -> datapath  clear to both counters
//   timer_enable        rcu -> datapath  bit-period counter enable
//   shift_strobe        rcu -> datapath  shift-register enable
//   load_buffer         rcu -> datapath  one-cycle rx buffer load
//   framing_error       rcu -> datapath  sticky framing error
//   rx_timeout          rcu -> datapath  sticky watchdog abort
//   busy                rcu -> datapath  frame in progress
//   parity_ok/parity_error  only when RX_RCU_PARITY_EN is defined
// Modports: slave = the control unit, master = the datapath/driver side.

interface rx_rcu_if;

  logic start_bit_detected;
  logic sample_tick;
  logic bits_done;
  logic stop_bit;
  logic timer_clear;
  logic timer_enable;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_timeout;
  logic busy;
`ifdef RX_RCU_PARITY_EN
  logic parity_ok;
  logic parity_error;
`endif

  modport slave (
    input  start_bit_detected, sample_tick, bits_done, stop_bit,
    output timer_clear, timer_enable, shift_strobe, load_buffer,
           framing_error, rx_timeout, busy
`ifdef RX_RCU_PARITY_EN
    , input parity_ok, output parity_error
`endif
  );

  modport master (
    output start_bit_detected, sample_tick, bits_done, stop_bit,
    input  timer_clear, timer_enable, shift_strobe, load_buffer,
           framing_error, rx_timeout, busy
`ifdef RX_RCU_PARITY_EN
    , output parity_ok, input parity_error
`endif
  );

endinterface

// File: rtl/rx_watchdog.sv
// rtl/rx_watchdog.sv - bit-timing stall watchdog for the receive control unit
//
// Purpose: counts RECEIVE cycles since the last sample_tick and flags a
// stall when the count reaches TIMEOUT_CYCLES-1 with no tick present.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   i_active    FSM is in RECEIVE this cycle
//   i_hold      FSM stays in RECEIVE next cycle (counter keeps running)
//   i_tick      sample_tick
//   o_timeout   stall detected this cycle (combinational)

module rx_watchdog import rx_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_BITS        = DEFAULT_TO_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_hold,
  input  logic i_tick,
  output logic o_timeout
);

  localparam logic [TO_BITS-1:0] LP_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

  logic [TO_BITS-1:0] r_count;

  // Clearing whenever the FSM is not going to remain in RECEIVE keeps the
  // count at zero in every other state, so each frame starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !i_hold || i_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TO_BITS'(1);
    end
  end

  assign o_timeout = i_active && !i_tick && (r_count == LP_LAST);

endmodule

// File: rtl/rx_rcu.sv
// rtl/rx_rcu.sv - receive control unit sequencing one serial frame
//
// Purpose: start-bit handoff, data shifting, stop-bit check and buffer
// load, with a watchdog that aborts frames whose bit timing stalls.
// Optional feature macro: RX_RCU_PARITY_EN (adds parity_ok/parity_error).
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   rx_rcu_if.slave: datapath flags in, counter/shift/load controls
//         and status flags out
// Parameters:
//   TIMEOUT_CYCLES  RECEIVE clocks without sample_tick before abort (>= 2)
//   TO_BITS         watchdog width, 2**TO_BITS >= TIMEOUT_CYCLES

module rx_rcu import rx_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_BITS        = DEFAULT_TO_BITS
) (
  input  logic     clk,
  input  logic     rst,
  rx_rcu_if.slave  bus
);

  rx_state_t r_state;
  rx_state_t w_next;

  logic w_timeout;
  logic w_active;
  logic w_hold;
  logic w_check_ok;

  logic w_timer_clear;
  logic w_timer_enable;
  logic w_shift_strobe;
  logic w_load_buffer;
  logic w_busy;

  logic r_framing_error;
  logic r_rx_timeout;

`ifdef RX_RCU_PARITY_EN
  logic r_parity_error;
  assign w_check_ok = bus.stop_bit && bus.parity_ok;
`else
  assign w_check_ok = bus.stop_bit;
`endif

  assign w_active = (r_state == ST_RECEIVE);
  assign w_hold   = w_active && (w_next == ST_RECEIVE);

  rx_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_BITS        (TO_BITS)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_hold    (w_hold),
    .i_tick    (bus.sample_tick),
    .o_timeout (w_timeout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.start_bit_detected) w_next = ST_START_CLR;
      ST_START_CLR: w_next = ST_RECEIVE;
      ST_RECEIVE: begin
        // bits_done wins over a watchdog expiry in the same cycle
        if (bus.bits_done)   w_next = ST_CHECK;
        else if (w_timeout)  w_next = ST_ERR;
      end
      ST_CHECK:     w_next = w_check_ok ? ST_LOAD : ST_ERR;
      ST_LOAD:      w_next = ST_IDLE;
      ST_ERR:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Output decode; shift_strobe is the only Mealy term so a tick coinciding
  // with bits_done still shifts the last bit.
  always_comb begin
    w_timer_clear  = 1'b0;
    w_timer_enable = 1'b0;
    w_shift_strobe = 1'b0;
    w_load_buffer  = 1'b0;
    w_busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_START_CLR: w_timer_clear = 1'b1;
      ST_RECEIVE: begin
        w_timer_enable = 1'b1;
        w_shift_strobe = bus.sample_tick;
      end
      ST_LOAD:      w_load_buffer = 1'b1;
      default:      ;
    endcase
  end

  // Sticky status flags: set on entry to ERR, held until the next frame's
  // START_CLR so software can still read them after the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_START_CLR) begin
      r_framing_error <= 1'b0;
      r_rx_timeout    <= 1'b0;
    end else begin
      if (r_state == ST_CHECK && !bus.stop_bit)
        r_framing_error <= 1'b1;
      if (w_timeout && !bus.bits_done)
        r_rx_timeout <= 1'b1;
    end
  end

`ifdef RX_RCU_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_START_CLR) begin
      r_parity_error <= 1'b0;
    end else if (r_state == ST_CHECK && !bus.parity_ok) begin
      r_parity_error <= 1'b1;
    end
  end
  assign bus.parity_error = r_parity_error;
`endif

  assign bus.timer_clear   = w_timer_clear;
  assign bus.timer_enable  = w_timer_enable;
  assign bus.shift_strobe  = w_shift_strobe;
  assign bus.load_buffer   = w_load_buffer;
  assign bus.busy          = w_busy;
  assign bus.framing_error = r_framing_error;
  assign bus.rx_timeout    = r_rx_timeout;

endmodule

// File: tb/tb_rx_rcu.sv
// tb/tb_rx_rcu.sv - directed self-checking bench for rx_rcu
//
// dut_a uses the default watchdog (64 cycles); dut_b uses an 8-cycle
// watchdog for the stall scenarios. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.

module tb_rx_rcu;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rx_rcu_if ifa ();
  rx_rcu_if ifb ();

  rx_rcu dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rx_rcu #(
    .TIMEOUT_CYCLES (8),
    .TO_BITS        (4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    ifa.start_bit_detected = 1'b0; ifa.sample_tick = 1'b0; ifa.bits_done = 1'b0;
    ifb.start_bit_detected = 1'b0; ifb.sample_tick = 1'b0; ifb.bits_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_strobes();
    ifa.stop_bit = 1'b0;
    ifb.stop_bit = 1'b0;
`ifdef RX_RCU_PARITY_EN
    ifa.parity_ok = 1'b1;
    ifb.parity_ok = 1'b1;
`endif
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Drives one 9-bit frame on dut_a: ticks 16 cycles apart, bits_done with
  // the 9th tick, a stray start pulse mid-frame, stop_bit presented in CHECK.
  // chain=1 pulses start in the first IDLE cycle after the frame;
  // skip_start=1 assumes the FSM is already in START_CLR.
  task automatic drive_frame_a(input logic stop, input logic chain, input logic skip_start,
                               output int strobes, output int loads, output int load_at,
                               output int bad_en, output logic busy_after);
    strobes = 0; loads = 0; load_at = -1; bad_en = 0; busy_after = 1'bx;
    if (!skip_start) begin
      ifa.start_bit_detected = 1'b1;
      next_cycle();
    end
    ifa.start_bit_detected = 1'b0;
    @(negedge clk);
    if (ifa.timer_clear !== 1'b1) bad_en++;
    next_cycle();
    for (int t = 1; t <= 9; t++) begin
      for (int c = 1; c <= 16; c++) begin
        ifa.sample_tick        = (c == 16);
        ifa.bits_done          = (c == 16) && (t == 9);
        ifa.start_bit_detected = (t == 3) && (c == 5);
        @(negedge clk);
        if (ifa.timer_enable !== 1'b1 || ifa.timer_clear !== 1'b0) bad_en++;
        if (ifa.shift_strobe === 1'b1) strobes++;
        if (ifa.load_buffer === 1'b1) loads++;
        next_cycle();
      end
    end
    clear_strobes();
    ifa.stop_bit = stop;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) ifa.start_bit_detected = chain;
      @(negedge clk);
      if (ifa.load_buffer === 1'b1) begin loads++; load_at = k; end
      if (ifa.shift_strobe === 1'b1) strobes++;
      if (k == 3) busy_after = ifa.busy;
      next_cycle();
    end
    ifa.start_bit_detected = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] va, vb;
    do_reset();
    @(negedge clk);
    va = {ifa.timer_clear, ifa.timer_enable, ifa.shift_strobe, ifa.load_buffer, ifa.framing_error, ifa.rx_timeout, ifa.busy};
    vb = {ifb.timer_clear, ifb.timer_enable, ifb.shift_strobe, ifb.load_buffer, ifb.framing_error, ifb.rx_timeout, ifb.busy};
    n_tests++; if (va !== 7'b0) begin n_fail++; $display("FAIL reset_outputs_a got=%b exp=0000000", va); end
    n_tests++; if (vb !== 7'b0) begin n_fail++; $display("FAIL reset_outputs_b got=%b exp=0000000", vb); end
    next_cycle();
  endtask

  task automatic test_nominal();
    int s, l, la, be; logic ba;
    drive_frame_a(1'b1, 1'b0, 1'b0, s, l, la, be, ba);
    @(negedge clk);
    n_tests++; if (s !== 9) begin n_fail++; $display("FAIL nominal_strobes got=%0d exp=9", s); end
    n_tests++; if (l !== 1) begin n_fail++; $display("FAIL nominal_loads got=%0d exp=1", l); end
    n_tests++; if (la !== 2) begin n_fail++; $display("FAIL nominal_load_at got=%0d exp=2", la); end
    n_tests++; if (be !== 0) begin n_fail++; $display("FAIL nominal_enable_cycles got=%0d bad exp=0", be); end
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL nominal_busy_after got=%b exp=0", ba); end
    n_tests++; if (ifa.framing_error !== 1'b0) begin n_fail++; $display("FAIL nominal_framing got=%b exp=0", ifa.framing_error); end
    next_cycle();
  endtask

  task automatic test_bad_stop();
    int s, l, la, be; logic ba; logic fe_held;
    drive_frame_a(1'b0, 1'b0, 1'b0, s, l, la, be, ba);
    @(negedge clk);
    n_tests++; if (l !== 0) begin n_fail++; $display("FAIL badstop_loads got=%0d exp=0", l); end
    n_tests++; if (s !== 9) begin n_fail++; $display("FAIL badstop_strobes got=%0d exp=9", s); end
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL badstop_busy_after got=%b exp=0", ba); end
    n_tests++; if (ifa.framing_error !== 1'b1) begin n_fail++; $display("FAIL badstop_framing got=%b exp=1", ifa.framing_error); end
    fe_held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      if (ifa.framing_error !== 1'b1) fe_held = 1'b0;
    end
    n_tests++; if (fe_held !== 1'b1) begin n_fail++; $display("FAIL badstop_framing_sticky got=%b exp=1", fe_held); end
    next_cycle();
    ifa.start_bit_detected = 1'b1;
    next_cycle();
    ifa.start_bit_detected = 1'b0;
    @(negedge clk);
    n_tests++; if (ifa.timer_clear !== 1'b1) begin n_fail++; $display("FAIL badstop_restart_clear got=%b exp=1", ifa.timer_clear); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (ifa.framing_error !== 1'b0) begin n_fail++; $display("FAIL badstop_framing_cleared got=%b exp=0", ifa.framing_error); end
    next_cycle();
    do_reset();
  endtask

  task automatic test_back_to_back();
    int s1, l1, la1, be1, s2, l2, la2, be2; logic ba1, ba2;
    drive_frame_a(1'b1, 1'b1, 1'b0, s1, l1, la1, be1, ba1);
    drive_frame_a(1'b1, 1'b0, 1'b1, s2, l2, la2, be2, ba2);
    n_tests++; if (l1 !== 1) begin n_fail++; $display("FAIL b2b_first_loads got=%0d exp=1", l1); end
    n_tests++; if (be2 !== 0) begin n_fail++; $display("FAIL b2b_second_enable got=%0d bad exp=0", be2); end
    n_tests++; if (s2 !== 9) begin n_fail++; $display("FAIL b2b_second_strobes got=%0d exp=9", s2); end
    n_tests++; if (la2 !== 2) begin n_fail++; $display("FAIL b2b_second_load_at got=%0d exp=2", la2); end
    n_tests++; if (ba2 !== 1'b0) begin n_fail++; $display("FAIL b2b_second_busy_after got=%b exp=0", ba2); end
  endtask

  task automatic test_reset_mid_frame();
    int s, l, la, be, late_loads; logic ba; logic [6:0] va;
    ifa.start_bit_detected = 1'b1;
    next_cycle();
    ifa.start_bit_detected = 1'b0;
    next_cycle();
    for (int t = 1; t <= 4; t++) begin
      for (int c = 1; c <= 16; c++) begin
        ifa.sample_tick = (c == 16);
        next_cycle();
      end
    end
    clear_strobes();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    va = {ifa.timer_clear, ifa.timer_enable, ifa.shift_strobe, ifa.load_buffer, ifa.framing_error, ifa.rx_timeout, ifa.busy};
    n_tests++; if (va !== 7'b0) begin n_fail++; $display("FAIL midreset_outputs got=%b exp=0000000", va); end
    late_loads = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      if (ifa.load_buffer !== 1'b0 || ifa.busy !== 1'b0) late_loads++;
    end
    n_tests++; if (late_loads !== 0) begin n_fail++; $display("FAIL midreset_idle_after got=%0d bad exp=0", late_loads); end
    next_cycle();
    drive_frame_a(1'b1, 1'b0, 1'b0, s, l, la, be, ba);
    n_tests++; if (s !== 9) begin n_fail++; $display("FAIL midreset_frame_strobes got=%0d exp=9", s); end
    n_tests++; if (la !== 2 || l !== 1) begin n_fail++; $display("FAIL midreset_frame_load got=%0d@%0d exp=1@2", l, la); end
    n_tests++; if (be !== 0) begin n_fail++; $display("FAIL midreset_frame_enable got=%0d bad exp=0", be); end
  endtask

  task automatic test_watchdog();
    int bad;
    ifb.start_bit_detected = 1'b1;
    next_cycle();
    ifb.start_bit_detected = 1'b0;
    next_cycle();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifb.timer_enable !== 1'b1 || ifb.rx_timeout !== 1'b0) bad++;
      next_cycle();
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wd_receive_cycles got=%0d bad exp=0", bad); end
    @(negedge clk);
    n_tests++; if (ifb.timer_enable !== 1'b0 || ifb.busy !== 1'b1) begin n_fail++; $display("FAIL wd_err_state got en=%b busy=%b exp en=0 busy=1", ifb.timer_enable, ifb.busy); end
    n_tests++; if (ifb.rx_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout_flag got=%b exp=1", ifb.rx_timeout); end
    n_tests++; if (ifb.load_buffer !== 1'b0) begin n_fail++; $display("FAIL wd_no_load got=%b exp=0", ifb.load_buffer); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (ifb.busy !== 1'b0 || ifb.rx_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_idle got busy=%b to=%b exp busy=0 to=1", ifb.busy, ifb.rx_timeout); end
    next_cycle();
  endtask

  task automatic test_done_vs_timeout();
    int bad;
    ifb.start_bit_detected = 1'b1;
    next_cycle();
    ifb.start_bit_detected = 1'b0;
    next_cycle();
    bad = 0;
    // 6 quiet cycles, a tick that restarts the count, 7 quiet cycles, then
    // bits_done on the exact cycle the watchdog would expire.
    for (int i = 1; i <= 15; i++) begin
      ifb.sample_tick = (i == 7);
      ifb.bits_done   = (i == 15);
      @(negedge clk);
      if (ifb.timer_enable !== 1'b1) bad++;
      next_cycle();
    end
    clear_strobes();
    ifb.stop_bit = 1'b1;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL dvt_receive_cycles got=%0d bad exp=0", bad); end
    @(negedge clk);
    n_tests++; if (ifb.busy !== 1'b1 || ifb.timer_enable !== 1'b0 || ifb.load_buffer !== 1'b0) begin n_fail++; $display("FAIL dvt_check_state got busy=%b en=%b ld=%b exp 1/0/0", ifb.busy, ifb.timer_enable, ifb.load_buffer); end
    n_tests++; if (ifb.rx_timeout !== 1'b0) begin n_fail++; $display("FAIL dvt_timeout_flag got=%b exp=0", ifb.rx_timeout); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (ifb.load_buffer !== 1'b1) begin n_fail++; $display("FAIL dvt_load got=%b exp=1", ifb.load_buffer); end
    next_cycle();
    ifb.stop_bit = 1'b0;
  endtask

`ifdef RX_RCU_PARITY_EN
  task automatic test_parity();
    int s, l, la, be; logic ba;
    ifa.parity_ok = 1'b0;
    drive_frame_a(1'b1, 1'b0, 1'b0, s, l, la, be, ba);
    @(negedge clk);
    n_tests++; if (l !== 0) begin n_fail++; $display("FAIL parity_loads got=%0d exp=0", l); end
    n_tests++; if (ifa.parity_error !== 1'b1) begin n_fail++; $display("FAIL parity_flag got=%b exp=1", ifa.parity_error); end
    n_tests++; if (ifa.framing_error !== 1'b0) begin n_fail++; $display("FAIL parity_framing got=%b exp=0", ifa.framing_error); end
    ifa.parity_ok = 1'b1;
    next_cycle();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_time_limit reached got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_nominal();
    test_bad_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_watchdog();
    test_done_vs_timeout();
`ifdef RX_RCU_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
